// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Request-driven binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It converts one binary bit per cycle, so a conversion takes BIN_W cycles.
//   It handles two's-complement input, overflow and leading-zero blanking.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   in_valid      request: bin / signed_mode are valid
//   in_ready      block is idle and can accept a request
//   bin           value to convert (BIN_W bits)
//   signed_mode   1 = bin is two's complement
//   out_valid     bcd/sign/overflow/blank hold a completed conversion
//   out_ready     consumer accepts the result
//   bcd           packed BCD, digit 0 (ones) in bits [3:0]
//   sign          input was negative (signed mode only)
//   overflow      magnitude exceeded 10^DIGITS - 1 (bcd holds value mod 10^DIGITS)
//   blank         bit i set when digit i and all higher digits are zero; bit 0 always 0

module bin2bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  signed_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  sign,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
      $error("bin2bcd_seq: BIN_W must be in 4..32");
   end
   if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS must be in 1..10");
   end

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;        // binary shift register
   logic [BCD_W-1:0]   scr_q, scr_d;        // BCD scratch
   logic               acc_ovf_q, acc_ovf_d;
   logic               acc_sign_q, acc_sign_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               sign_q, sign_d;
   logic               overflow_q, overflow_d;
   logic [DIGITS-1:0]  blank_q, blank_d;

   logic [BCD_W-1:0]   adj;
   logic [BCD_W-1:0]   scr_shift;
   logic [BIN_W-1:0]   bin_shift;
   logic               ovf_now;
   logic [DIGITS-1:0]  blank_new;
   logic               neg;

   // Add-3 correction on every digit >= 5, then shift {scratch, binary} left.
   // The bit leaving the top digit is a carry past 10^DIGITS, i.e. overflow.
   always_comb begin
      logic [3:0] dig;
      logic       all_zero;
      adj      = '0;
      dig      = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         dig            = scr_q[4*i +: 4];
         adj[4*i +: 4]  = (dig >= 4'd5) ? dig + 4'd3 : dig;
      end
      scr_shift = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_shift = {bin_q[BIN_W-2:0], 1'b0};
      ovf_now   = acc_ovf_q | adj[BCD_W-1];

      // Blanking scans from the top digit down; the ones digit is never blanked.
      blank_new = '0;
      all_zero  = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         all_zero     = all_zero & (scr_shift[4*i +: 4] == 4'd0);
         blank_new[i] = all_zero;
      end
   end

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      scr_d      = scr_q;
      acc_ovf_d  = acc_ovf_q;
      acc_sign_d = acc_sign_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      sign_d     = sign_q;
      overflow_d = overflow_q;
      blank_d    = blank_q;
      neg        = signed_mode & bin[BIN_W-1];

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // BIN_W-bit negation; the most-negative input maps to 2^(BIN_W-1).
               bin_d      = neg ? (~bin + BIN_W'(1)) : bin;
               scr_d      = '0;
               acc_ovf_d  = 1'b0;
               acc_sign_d = neg;
               cnt_d      = '0;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            scr_d     = scr_shift;
            bin_d     = bin_shift;
            acc_ovf_d = ovf_now;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d    = DONE;
               bcd_d      = scr_shift;
               sign_d     = acc_sign_q;
               overflow_d = ovf_now;
               blank_d    = blank_new;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         scr_q      <= '0;
         acc_ovf_q  <= 1'b0;
         acc_sign_q <= 1'b0;
         cnt_q      <= '0;
         bcd_q      <= '0;
         sign_q     <= 1'b0;
         overflow_q <= 1'b0;
         blank_q    <= '0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         scr_q      <= scr_d;
         acc_ovf_q  <= acc_ovf_d;
         acc_sign_q <= acc_sign_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         sign_q     <= sign_d;
         overflow_q <= overflow_d;
         blank_q    <= blank_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign bcd       = bcd_q;
   assign sign      = sign_q;
   assign overflow  = overflow_q;
   assign blank     = blank_q;

endmodule
